// File: rtl/bus_pkg.sv
// bus_pkg: request/response types, field offsets and master IDs for bus_ctrl_xbar
package bus_pkg;
  typedef struct packed {
    logic [31:0] a;
    logic        r;
    logic        w;
    logic [31:0] wd;
    logic [3:0]  wbe;
  } req_t;
  typedef struct packed {
    logic        hold;
    logic        rdv;
    logic [31:0] rd;
  } res_t;
  localparam int REQ_W = $bits(req_t);
  localparam int RES_W = $bits(res_t);
  localparam int REQ_WBE_LSB = 0;
  localparam int REQ_WD_LSB = 4;
  localparam int REQ_W_BIT = 36;
  localparam int REQ_R_BIT = 37;
  localparam int REQ_A_LSB = 38;
  localparam int RES_RD_LSB = 0;
  localparam int RES_RDV_BIT = 32;
  localparam int RES_HOLD_BIT = 33;
  typedef enum logic [1:0] {MID_NONE = 2'd0, MID_M1 = 2'd1, MID_M2 = 2'd2, MID_M3 = 2'd3} mid_e;
  localparam logic [7:0] PERIPH_BASE_DEF = 8'hFF;
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order master-ID FIFO; a push into a full FIFO is taken when a pop happens in the same cycle
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] lvl;
  logic do_push, do_pop;
  assign full = lvl == (AW+1)'(DEPTH);
  assign empty = lvl == '0;
  assign dout = mem[rp];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      lvl <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      lvl <= lvl + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/bus_ctrl_xbar.sv
// bus_ctrl_xbar: 3-master / 2-target fixed-priority interconnect with in-order read return.
// Target2 (peripheral) path is built only when BUS_CTRL_PERIPH_EN is defined.
module bus_ctrl_xbar
  import bus_pkg::*;
#(
  parameter int         TAG_DEPTH   = 4,
  parameter logic [7:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  req_t master1_req,
  output res_t master1_res,
  input  req_t master2_req,
  output res_t master2_res,
  input  req_t master3_req,
  output res_t master3_res,
  output req_t target1_req,
  input  res_t target1_res,
  output req_t target2_req,
  input  res_t target2_res
);
`ifdef BUS_CTRL_PERIPH_EN
  localparam int NT = 2;
`else
  localparam int NT = 1;
`endif
  localparam int CW = $clog2(2*TAG_DEPTH+1);
  req_t mreq [3];
  res_t mres [3];
  req_t treq [NT];
  res_t tres [NT];
  logic tsel [3];
  logic [2:0] sw_blk, acc;
  logic [NT-1:0] elig [3];
  logic [NT-1:0] gnt [3];
  logic [NT-1:0] full, empty, push, pop, thold;
  logic [1:0] head [NT];
  logic [1:0] win [NT];
  logic [CW-1:0] cnt [3];
`ifdef BUS_CTRL_PERIPH_EN
  logic cur [3];
`endif
  assign mreq[0] = master1_req;
  assign mreq[1] = master2_req;
  assign mreq[2] = master3_req;
  assign master1_res = mres[0];
  assign master2_res = mres[1];
  assign master3_res = mres[2];
  assign tres[0] = target1_res;
  assign target1_req = treq[0];
`ifdef BUS_CTRL_PERIPH_EN
  assign tres[1] = target2_res;
  assign target2_req = treq[1];
`else
  logic unused_t2;
  assign target2_req = '0;
  assign unused_t2 = ^target2_res;
`endif
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      pop[t] = rst_n && tres[t].rdv && !empty[t];
      thold[t] = tres[t].hold;
    end
    for (int i = 0; i < 3; i++) begin
      tsel[i] = 1'b0;
      sw_blk[i] = 1'b0;
`ifdef BUS_CTRL_PERIPH_EN
      tsel[i] = mreq[i].a[31:24] == PERIPH_BASE;
      sw_blk[i] = cnt[i] != '0 && cur[i] != tsel[i];
`endif
      // a read may use a tag slot freed by a same-cycle return
      for (int t = 0; t < NT; t++)
        elig[i][t] = rst_n && (mreq[i].r || mreq[i].w) && int'(tsel[i]) == t
                     && !(mreq[i].r && ((full[t] && !pop[t]) || sw_blk[i]));
    end
    for (int t = 0; t < NT; t++) begin
      gnt[0][t] = elig[0][t];
      gnt[1][t] = elig[1][t] && !elig[0][t];
      gnt[2][t] = elig[2][t] && !elig[0][t] && !elig[1][t];
      win[t] = gnt[0][t] ? 2'(MID_M1) : gnt[1][t] ? 2'(MID_M2) : 2'(MID_M3);
      treq[t] = gnt[0][t] ? mreq[0] : gnt[1][t] ? mreq[1] : gnt[2][t] ? mreq[2] : '0;
      push[t] = (gnt[0][t] || gnt[1][t] || gnt[2][t]) && treq[t].r && !thold[t];
    end
    for (int i = 0; i < 3; i++) begin
      acc[i] = |(gnt[i] & ~thold);
      mres[i] = '0;
      mres[i].hold = !rst_n || ((mreq[i].r || mreq[i].w) && !acc[i]);
      for (int t = 0; t < NT; t++)
        if (pop[t] && head[t] == 2'(i + 1)) begin
          mres[i].rdv = 1'b1;
          mres[i].rd = tres[t].rd;
        end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) cnt[i] <= cnt[i] + CW'(acc[i] && mreq[i].r) - CW'(mres[i].rdv);
    end
`ifdef BUS_CTRL_PERIPH_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cur[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) if (acc[i] && mreq[i].r) cur[i] <= tsel[i];
    end
`endif
  for (genvar t = 0; t < NT; t++) begin : g_fifo
    tag_fifo #(.DEPTH(TAG_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push[t]), .pop(pop[t]), .din(win[t]),
      .dout(head[t]), .full(full[t]), .empty(empty[t])
    );
  end
endmodule

// File: tb/tb_bus_ctrl_xbar.sv
// tb_bus_ctrl_xbar: directed checks of arbitration, tag FIFOs, target hold and reset for bus_ctrl_xbar
module tb_bus_ctrl_xbar;
  import bus_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  req_t m1q, m2q, m3q, t1q, t2q;
  res_t m1s, m2s, m3s, t1s, t2s;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  bus_ctrl_xbar dut (
    .clk(clk), .rst_n(rst_n),
    .master1_req(m1q), .master1_res(m1s),
    .master2_req(m2q), .master2_res(m2s),
    .master3_req(m3q), .master3_res(m3s),
    .target1_req(t1q), .target1_res(t1s),
    .target2_req(t2q), .target2_res(t2s)
  );
  function automatic req_t rd_req(logic [31:0] a);
    req_t q = '0;
    q.a = a;
    q.r = 1'b1;
    return q;
  endfunction
  function automatic req_t wr_req(logic [31:0] a, logic [31:0] wd, logic [3:0] wbe);
    req_t q = '0;
    q.a = a;
    q.w = 1'b1;
    q.wd = wd;
    q.wbe = wbe;
    return q;
  endfunction
  function automatic res_t ret(logic [31:0] rd);
    res_t s = '0;
    s.rdv = 1'b1;
    s.rd = rd;
    return s;
  endfunction
  task automatic chk1(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chkq(string tag, req_t obs, req_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    m1q = '0; m2q = '0; m3q = '0; t1s = '0; t2s = '0;
    m1q = rd_req(32'h4000_0000);
    #2;
    chk1("rst_m1_hold", m1s.hold, 1'b1);
    chk1("rst_m2_hold", m2s.hold, 1'b1);
    chk1("rst_m1_rdv", m1s.rdv, 1'b0);
    chkq("rst_t1_idle", t1q, '0);
    chkq("rst_t2_idle", t2q, '0);
    tick();
    rst_n = 1'b1;
    m3q = rd_req(32'h4000_0000);
    #2;
    chkq("arb_t1_m1", t1q, m1q);
    chk1("arb_m1_hold", m1s.hold, 1'b0);
    chk1("arb_m3_hold", m3s.hold, 1'b1);
    chk1("idle_m2_hold", m2s.hold, 1'b0);
    tick();
    m1q = '0;
    #2;
    chkq("arb_t1_m3", t1q, m3q);
    chk1("arb_m3_go", m3s.hold, 1'b0);
    tick();
    m3q = '0;
    t1s = ret(32'h1111_1111);
    #2;
    chk1("ret1_m1_rdv", m1s.rdv, 1'b1);
    chk32("ret1_m1_rd", m1s.rd, 32'h1111_1111);
    chk1("ret1_m3_rdv", m3s.rdv, 1'b0);
    chk32("ret1_m3_rd", m3s.rd, 32'h0);
    tick();
    t1s = ret(32'h2222_2222);
    #2;
    chk1("ret2_m3_rdv", m3s.rdv, 1'b1);
    chk32("ret2_m3_rd", m3s.rd, 32'h2222_2222);
    chk1("ret2_m1_rdv", m1s.rdv, 1'b0);
    tick();
    t1s = '0;
    for (int k = 0; k < 4; k++) begin
      m3q = rd_req(32'h4000_0100 + 32'(k * 4));
      #2;
      chk1("fill_m3_hold", m3s.hold, 1'b0);
      tick();
    end
    m3q = rd_req(32'h4000_0200);
    #2;
    chk1("full_m3_hold", m3s.hold, 1'b1);
    chkq("full_t1_idle", t1q, '0);
    tick();
    t1s = ret(32'h3333_3333);
    #2;
    chk1("full_pop_m3_hold", m3s.hold, 1'b0);
    chkq("full_pop_t1", t1q, m3q);
    chk1("full_pop_m3_rdv", m3s.rdv, 1'b1);
    tick();
    m3q = '0;
    for (int k = 0; k < 4; k++) begin
      t1s = ret(32'h0000_0A00 + 32'(k));
      #2;
      chk1("drain_m3_rdv", m3s.rdv, 1'b1);
      chk32("drain_m3_rd", m3s.rd, 32'h0000_0A00 + 32'(k));
      tick();
    end
    t1s = ret(32'h4444_4444);
    #2;
    chk1("stray_m1_rdv", m1s.rdv, 1'b0);
    chk1("stray_m2_rdv", m2s.rdv, 1'b0);
    chk1("stray_m3_rdv", m3s.rdv, 1'b0);
    tick();
    t1s = '0;
    t1s.hold = 1'b1;
    m1q = rd_req(32'h4000_0020);
    #2;
    chk1("thold_m1_hold", m1s.hold, 1'b1);
    chkq("thold_t1_fwd", t1q, m1q);
    tick();
    t1s = '0;
    #2;
    chk1("thold_m1_go", m1s.hold, 1'b0);
    tick();
    m1q = '0;
    t1s = ret(32'h5555_5555);
    #2;
    chk1("thold_ret_m1_rdv", m1s.rdv, 1'b1);
    chk32("thold_ret_m1_rd", m1s.rd, 32'h5555_5555);
    tick();
    t1s = '0;
    m2q = rd_req(32'h4000_0010);
    m3q = wr_req(32'hFF00_0000, 32'h41, 4'b0001);
    #2;
    chkq("par_t1_m2", t1q, m2q);
    chk1("par_m2_hold", m2s.hold, 1'b0);
`ifdef BUS_CTRL_PERIPH_EN
    chkq("par_t2_m3", t2q, m3q);
    chk1("par_m3_hold", m3s.hold, 1'b0);
    tick();
    m2q = '0;
    m3q = '0;
`else
    chk1("nop_m3_hold", m3s.hold, 1'b1);
    chkq("nop_t2_zero", t2q, '0);
    tick();
    m2q = '0;
    #2;
    chkq("nop_t1_m3", t1q, m3q);
    chkq("nop_t2_still_zero", t2q, '0);
    tick();
    m3q = '0;
`endif
    t1s = ret(32'h6666_6666);
    #2;
    chk1("par_ret_m2_rdv", m2s.rdv, 1'b1);
    chk32("par_ret_m2_rd", m2s.rd, 32'h6666_6666);
    tick();
    t1s = '0;
`ifdef BUS_CTRL_PERIPH_EN
    m3q = rd_req(32'h4000_0000);
    tick();
    m3q = rd_req(32'hFF00_0004);
    #2;
    chk1("sw_m3_hold", m3s.hold, 1'b1);
    chkq("sw_t2_idle", t2q, '0);
    tick();
    t1s = ret(32'h7777_7777);
    #2;
    chk1("sw_ret_m3_rdv", m3s.rdv, 1'b1);
    chk1("sw_ret_m3_hold", m3s.hold, 1'b1);
    tick();
    t1s = '0;
    #2;
    chk1("sw_m3_go", m3s.hold, 1'b0);
    chkq("sw_t2_m3", t2q, m3q);
    tick();
    m3q = '0;
    t2s = ret(32'h8888_8888);
    #2;
    chk1("sw_t2_ret_rdv", m3s.rdv, 1'b1);
    chk32("sw_t2_ret_rd", m3s.rd, 32'h8888_8888);
    tick();
    t2s = '0;
`endif
    m2q = rd_req(32'h4000_0040);
    tick();
    m2q = rd_req(32'h4000_0044);
    tick();
    m1q = rd_req(32'h4000_0080);
    rst_n = 1'b0;
    #2;
    chk1("rst2_m1_hold", m1s.hold, 1'b1);
    chk1("rst2_m2_hold", m2s.hold, 1'b1);
    chk1("rst2_m3_hold", m3s.hold, 1'b1);
    chkq("rst2_t1_idle", t1q, '0);
    chkq("rst2_t2_idle", t2q, '0);
    tick();
    rst_n = 1'b1;
    m1q = '0;
    m2q = '0;
    t1s = ret(32'hDEAD_BEEF);
    #2;
    chk1("post_rst_m2_rdv", m2s.rdv, 1'b0);
    chk32("post_rst_m2_rd", m2s.rd, 32'h0);
    chk1("post_rst_m1_rdv", m1s.rdv, 1'b0);
    tick();
    t1s = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
